// File: rtl/snn_output_collector.sv
// Collects output-layer spikes per tick window, then picks the class with the most spikes.
// Result appears NUM_CLASSES+1 cycles after tick; a tick arriving before the previous result is accepted discards its window.
module snn_output_collector #(
  parameter int NUM_OUTPUT    = 250,
  parameter int PACKET_W      = 8,
  parameter int NUM_CLASSES   = 10,
  parameter int CNT_W         = 8,
  parameter int REVERSE_INDEX = 1
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           tick,
  input  logic [PACKET_W-1:0]            packet_out,
  input  logic                           packet_out_valid,
  input  logic                           result_ready,
  output logic                           result_valid,
  output logic [NUM_OUTPUT-1:0]          spike_vector,
  output logic [$clog2(NUM_CLASSES)-1:0] class_id,
  output logic [CNT_W-1:0]               class_count,
  output logic [$clog2(NUM_OUTPUT+1)-1:0] spike_total,
  output logic                           index_error,
  output logic                           result_dropped
);

  localparam int IDX_W = (NUM_OUTPUT > 1) ? $clog2(NUM_OUTPUT) : 1;
  localparam int CLS_W = $clog2(NUM_CLASSES);
  localparam int TOT_W = $clog2(NUM_OUTPUT + 1);
  localparam int EXT_W = ((PACKET_W > IDX_W) ? PACKET_W : IDX_W) + 1;

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

  state_t             state;
  logic [NUM_OUTPUT-1:0] acc_vec, snap_vec;
  logic [CNT_W-1:0]   acc_cnt  [NUM_CLASSES];
  logic [CNT_W-1:0]   snap_cnt [NUM_CLASSES];
  logic [TOT_W-1:0]   acc_total, snap_total;
  logic [CLS_W-1:0]   k, best_id;
  logic [CNT_W-1:0]   best_cnt;

  logic [EXT_W-1:0]   pkt_ext, bit_ext;
  logic               pkt_ok, pkt_new;
  logic [IDX_W-1:0]   bit_idx;
  logic [CLS_W-1:0]   bit_cls;

  always_comb begin
    pkt_ext = EXT_W'(packet_out);
    pkt_ok  = packet_out_valid && (pkt_ext < EXT_W'(NUM_OUTPUT));
    bit_ext = (REVERSE_INDEX != 0) ? (EXT_W'(NUM_OUTPUT - 1) - pkt_ext) : pkt_ext;
    bit_idx = bit_ext[IDX_W-1:0];
    bit_cls = CLS_W'(32'(bit_idx) % NUM_CLASSES);
    // a packet coincident with tick lands in the freshly cleared window, so it is always new
    pkt_new = pkt_ok && (tick || !acc_vec[bit_idx]);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_vec   <= '0;
      acc_total <= '0;
      for (int i = 0; i < NUM_CLASSES; i++) acc_cnt[i] <= '0;
    end else begin
      if (tick) begin
        acc_vec   <= '0;
        acc_total <= '0;
        for (int i = 0; i < NUM_CLASSES; i++) acc_cnt[i] <= '0;
      end
      if (pkt_new) begin
        acc_vec[bit_idx] <= 1'b1;
        acc_total        <= tick ? TOT_W'(1) : acc_total + TOT_W'(1);
        if (tick)
          acc_cnt[bit_cls] <= CNT_W'(1);
        else if (acc_cnt[bit_cls] != {CNT_W{1'b1}})
          acc_cnt[bit_cls] <= acc_cnt[bit_cls] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= S_IDLE;
      snap_vec       <= '0;
      snap_total     <= '0;
      for (int i = 0; i < NUM_CLASSES; i++) snap_cnt[i] <= '0;
      k              <= '0;
      best_id        <= '0;
      best_cnt       <= '0;
      result_valid   <= 1'b0;
      index_error    <= 1'b0;
      result_dropped <= 1'b0;
    end else begin
      index_error    <= packet_out_valid && !pkt_ok;
      result_dropped <= tick && (state != S_IDLE);
      case (state)
        S_IDLE: begin
          if (tick) begin
            snap_vec   <= acc_vec;
            snap_total <= acc_total;
            for (int i = 0; i < NUM_CLASSES; i++) snap_cnt[i] <= acc_cnt[i];
            k        <= '0;
            best_id  <= '0;
            best_cnt <= '0;
            state    <= S_SCAN;
          end
        end
        S_SCAN: begin
          // strict compare keeps the lowest class id on ties
          if (snap_cnt[k] > best_cnt) begin
            best_id  <= k;
            best_cnt <= snap_cnt[k];
          end
          if (k == CLS_W'(NUM_CLASSES - 1))
            state <= S_DONE;
          else
            k <= k + CLS_W'(1);
        end
        S_DONE: begin
          if (!result_valid) begin
            result_valid <= 1'b1;
          end else if (result_ready) begin
            result_valid <= 1'b0;
            state        <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign spike_vector = snap_vec;
  assign spike_total  = snap_total;
  assign class_id     = best_id;
  assign class_count  = best_cnt;

endmodule

// File: doc/snn_output_collector.md
Name: snn_output_collector

Overview:
- Synthesisable on-chip replacement for software spike scoring after the last RANC core.
- Accumulates output spike packets between ticks into a NUM_OUTPUT-bit spike vector and per-class spike counts.
- On each tick: snapshots the window, runs a sequential argmax over classes, and presents {spike vector, winning class, count, total} on a valid/ready result port.
- Generalises the fixed 250-output, bitmap-only scoring to parametrised output count, class count, index ordering and counter width, and adds classification, error flags and back-pressure.

Parameters:
- NUM_OUTPUT, 250: number of output neurons (valid packet indices 0..NUM_OUTPUT-1).
- PACKET_W, 8: width of the packet_out index.
- NUM_CLASSES, 10: class count; neuron i belongs to class (i mod NUM_CLASSES).
- CNT_W, 8: per-class counter width; counters saturate.
- REVERSE_INDEX, 1: 1 → spike bit = NUM_OUTPUT-1-packet_out; 0 → bit = packet_out.

Ports:
- clk  in  1  core clock.
- reset_n  in  1  reset; one clock; reset is asynchronous and active-low.
- tick  in  1  one-cycle pulse; closes the current window.
- packet_out  in  PACKET_W  output neuron index.
- packet_out_valid  in  1  index valid this cycle.
- result_ready  in  1  consumer accepts the result.
- result_valid  out  1  result registers valid.
- spike_vector  out  NUM_OUTPUT  snapshot of the closed window.
- class_id  out  $clog2(NUM_CLASSES)  winning class.
- class_count  out  CNT_W  spike count of the winning class.
- spike_total  out  $clog2(NUM_OUTPUT+1)  number of set bits in the snapshot.
- index_error  out  1  one-cycle pulse on an index ≥ NUM_OUTPUT.
- result_dropped  out  1  one-cycle pulse when a window is discarded.

Behaviour:
- Reset (async assert, sync deassert use):
  - All outputs 0.
  - Accumulator vector, class counters and total are 0.
  - FSM is in IDLE.
- Accumulate: when packet_out_valid=1 and the index is < NUM_OUTPUT, map it to bit b.
  - If bit b is clear: set it, increment counter[b mod NUM_CLASSES] (saturating at 2^CNT_W-1), and increment the running total.
  - If bit b is already set: the duplicate is ignored; no count change.
- Out-of-range index: no state change; index_error=1 on the next cycle.
- tick at cycle T:
  - The accumulator vector, counters and total are copied to snapshot registers at the T edge, and the accumulator is cleared at the same edge.
  - A packet_out_valid coincident with tick belongs to the NEW window: it is applied after the clear, so the new window starts with that bit set.
- FSM:
  - IDLE → SCAN on tick: best_id=0, best_cnt=0, k=0.
  - SCAN: one class per cycle. If snap_cnt[k] > best_cnt, update best_id and best_cnt (strict >, so ties keep the lowest class id). k increments; after k=NUM_CLASSES-1, go to DONE.
  - DONE: result_valid=1. Outputs hold stable until result_ready=1; the handshake completes on the result_valid && result_ready edge, then result_valid→0 and the FSM returns to IDLE.
- Latency: tick sampled at edge T → result_valid high from edge T+NUM_CLASSES+1.
- tick while the FSM is not IDLE:
  - The accumulator is still cleared, but its contents are discarded.
  - The snapshot and the in-flight result are untouched.
  - result_dropped pulses for 1 cycle.
- If result_ready is already high on entry to DONE, result_valid is high for exactly 1 cycle.
- Reset asserted mid-SCAN or mid-DONE: immediate return to the reset state; no partial result survives.
- All-zero window: class_id=0, class_count=0, spike_total=0, spike_vector=0.

Test Plan:
1. Reset, then packets 0 and 249, then tick (REVERSE_INDEX=1). Required: spike_vector bits 249 and 0 set, spike_total=2, class_id=0 (class 9 and class 0 both count 1; tie → lowest), result_valid at T+11.
2. Three packets mapping to class 3 plus one each to classes 1 and 7, then tick. Required: class_id=3, class_count=3, spike_total=5.
3. Same index sent 4 times, then tick. Required: spike_total=1, class_count=1 (duplicates ignored).
4. packet_out=250 with valid. Required: index_error pulses 1 cycle; after tick, spike_vector=0.
5. Hold result_ready=0 and issue a second tick during DONE. Required: result_dropped pulses, first result outputs unchanged; after a ready handshake the FSM is IDLE and the next window accumulates from zero.
6. CNT_W=2, 5 spikes in a single class. Required: class_count=3 (saturated), spike_total=5. Also: valid coincident with tick → that bit appears in the next window's snapshot only.
